// File: rtl/demod_cmul.sv
// demod_cmul: FM discriminator front half. Multiplies each complex sample by the
// conjugate of the previous one, dequantizes the four partial products and pushes
// imag to the A FIFO and real to the B FIFO (y/x operands for the arctan stage).
module demod_cmul #(
   parameter int DATA_WIDTH = 32,
   parameter int QUANT_VAL  = 10
) (
   input  logic                  clock,
   input  logic                  reset,
   output logic                  inI_rd_en,
   input  logic                  inI_empty,
   input  logic [DATA_WIDTH-1:0] inI_dout,
   output logic                  inQ_rd_en,
   input  logic                  inQ_empty,
   input  logic [DATA_WIDTH-1:0] inQ_dout,
   output logic                  outA_wr_en,
   input  logic                  outA_full,
   output logic [DATA_WIDTH-1:0] outA_din,
   output logic                  outB_wr_en,
   input  logic                  outB_full,
   output logic [DATA_WIDTH-1:0] outB_din
);

   localparam int PW = 2 * DATA_WIDTH;
   // Added to negative products so the arithmetic shift truncates toward zero.
   localparam logic signed [PW-1:0] Bias = {{(PW - QUANT_VAL){1'b0}}, {QUANT_VAL{1'b1}}};

   typedef enum logic [1:0] {StRead, StMult, StWrite} state_e;

   state_e state_q, state_d;

   logic signed [DATA_WIDTH-1:0] cur_r_q, cur_i_q, prev_r_q, prev_i_q;
   logic signed [PW-1:0]         p0_q, p1_q, p2_q, p3_q;
   logic signed [PW-1:0]         prev_r_x, prev_i_x, cur_r_x, cur_i_x;
   logic                         pop, push;
   logic [DATA_WIDTH-1:0]        real_res, imag_res;

   // Signed divide by 2^QUANT_VAL, truncating toward zero; only the low word survives.
   function automatic logic [DATA_WIDTH-1:0] dq(input logic signed [PW-1:0] x);
      logic signed [PW-1:0] t;
      t = (x < 0) ? (x + Bias) : x;
      t = t >>> QUANT_VAL;
      return t[DATA_WIDTH-1:0];
   endfunction

   // Sign-extend operands to full product width and qualify the handshakes.
   always_comb begin
      prev_r_x = {{DATA_WIDTH{prev_r_q[DATA_WIDTH-1]}}, prev_r_q};
      prev_i_x = {{DATA_WIDTH{prev_i_q[DATA_WIDTH-1]}}, prev_i_q};
      cur_r_x  = {{DATA_WIDTH{cur_r_q[DATA_WIDTH-1]}}, cur_r_q};
      cur_i_x  = {{DATA_WIDTH{cur_i_q[DATA_WIDTH-1]}}, cur_i_q};
      // Reset gates both handshakes so nothing is popped or written in a reset cycle.
      pop  = (state_q == StRead) && !inI_empty && !inQ_empty && !reset;
      push = (state_q == StWrite) && !outA_full && !outB_full && !reset;
   end

   // Dequantize and combine products; low DATA_WIDTH bits wrap naturally.
   always_comb begin
      real_res = dq(p0_q) - dq(p1_q);
      imag_res = dq(p2_q) + dq(p3_q);
      outA_din = imag_res;
      outB_din = real_res;
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StRead;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StRead:  if (pop) state_d = StMult;
         StMult:  state_d = StWrite;
         StWrite: if (push) state_d = StRead;
         default: state_d = StRead;
      endcase
   end

   // Output logic: FIFO strobes always move in pairs.
   always_comb begin
      inI_rd_en  = 1'b0;
      inQ_rd_en  = 1'b0;
      outA_wr_en = 1'b0;
      outB_wr_en = 1'b0;
      unique case (state_q)
         StRead: begin
            inI_rd_en = pop;
            inQ_rd_en = pop;
         end
         StWrite: begin
            outA_wr_en = push;
            outB_wr_en = push;
         end
         default: ;
      endcase
   end

   // Datapath: capture sample, form products, commit history on write.
   always_ff @(posedge clock) begin
      if (reset) begin
         cur_r_q  <= '0;
         cur_i_q  <= '0;
         prev_r_q <= '0;
         prev_i_q <= '0;
         p0_q     <= '0;
         p1_q     <= '0;
         p2_q     <= '0;
         p3_q     <= '0;
      end else begin
         unique case (state_q)
            StRead: begin
               if (pop) begin
                  cur_r_q <= inI_dout;
                  cur_i_q <= inQ_dout;
               end
            end
            StMult: begin
               p0_q <= prev_r_x * cur_r_x;
               p1_q <= -(prev_i_x * cur_i_x);
               p2_q <= prev_r_x * cur_i_x;
               p3_q <= -(prev_i_x * cur_r_x);
            end
            StWrite: begin
               if (push) begin
                  prev_r_q <= cur_r_q;
                  prev_i_q <= cur_i_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
